pe_context_sequencer: RTL and testbench
=======================================

# pe_context_sequencer

Configuration sequencer for one king-mesh PE. Holds a small context memory loaded by the host, then on `start` replays `ctx_len` context words per iteration for `iter_cnt` iterations onto the PE's `configuration` input, one word per cycle. After the last word it drains and signals completion. Sits between the array-level host/config loader and the PE's 24-bit `configuration` port; bit 0 of each stored word is the PE context-bank select.

## Interface
- `ContextWidth`, 24, width of one context word; matches the PE `configuration` port.
- `Depth`, 16, number of context-memory entries.
- `AddrWidth`, 4, log2(`Depth`).
- `IterWidth`, 16, width of the iteration counter.
- `DrainCycles`, 2, cycles the last word is held after issue so PE results settle.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `cfg_wr_en` in 1: write strobe for context memory.
- `cfg_wr_addr` in `AddrWidth`: write address.
- `cfg_wr_data` in `ContextWidth`: context word to store.
- `start` in 1: single-cycle run request.
- `ctx_len` in `AddrWidth`+1: words per iteration, legal range 1..`Depth`.
- `iter_cnt` in `IterWidth`: iteration count, legal range ≥1.
- `configuration` out `ContextWidth`: registered word driven to the PE.
- `busy` out 1: high while a run is in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse when `start` is rejected.
- `ctx_idx` out `AddrWidth`: address of the word currently on `configuration`.
- `iter_idx` out `IterWidth`: index of the current iteration, 0-based.

## Operation
- State machine states:
  - IDLE → RUN on a legal `start`.
  - RUN → DRAIN after the word at (`ctx_idx`=`ctx_len`-1, `iter_idx`=`iter_cnt`-1) is issued.
  - DRAIN → DONE after `DrainCycles` cycles.
  - DONE → IDLE unconditionally (one cycle).
- `ctx_len` and `iter_cnt` are sampled into internal registers only on an accepted `start`. Changing the inputs mid-run has no effect.
- Illegal `start` is rejected: `ctx_len`=0, `ctx_len`>`Depth`, or `iter_cnt`=0. On rejection, `err` pulses the next cycle, state stays IDLE, and `configuration` is unchanged.
- `start` is ignored outside IDLE: no `err`, no restart.
- RUN: each cycle `configuration` ← mem[`ctx_idx`]. `ctx_idx` wraps from `ctx_len`-1 to 0 and increments `iter_idx` at the same edge.
- DRAIN, DONE and IDLE: `configuration` holds the last issued word. The PE therefore rewrites the same bank with the same value, which is benign.
- Memory writes are accepted only while `busy`=0; they are dropped while busy.
- A write in the same cycle as an accepted `start` is performed. Memory reads are read-before-write, so if the write targets address 0, the first issued word is the old contents.
- Memory contents are not cleared by `rst`.

## Timing
- Reset values (next edge after `rst`=1): `configuration`=0, `busy`=0, `done`=0, `err`=0, `ctx_idx`=0, `iter_idx`=0, state=IDLE.
- `rst` mid-run aborts the run the next edge: no `done`, and all outputs go to their reset values.
- Let N = `ctx_len`×`iter_cnt` and let the accepted `start` be in cycle T.
  - `configuration`=mem[0] and `busy`=1 from cycle T+1.
  - Words are issued in cycles T+1..T+N, back-to-back with no bubbles.
  - DRAIN occupies T+N+1..T+N+`DrainCycles`, with `busy`=1.
  - `done`=1 and `busy`=0 in cycle T+N+`DrainCycles`+1.
- Earliest next `start` accepted: cycle T+N+`DrainCycles`+2.
- `err` is asserted in cycle T+1 for a rejected `start` in cycle T.
- `ctx_idx`/`iter_idx` are registered and aligned with `configuration`. During DRAIN/DONE/IDLE they hold their last values.
- N up to `Depth`×(2^`IterWidth`-1). Counters must not overflow; `iter_idx` width equals `IterWidth`.

## Structure
- Package `pe_ctrl_pkg` holds:
  - the state enumeration (IDLE, RUN, DRAIN, DONE);
  - default `ContextWidth`/`Depth`/`IterWidth` constants;
  - the context-word field positions shared with PE tooling:
    - bit 0: bank select;
    - bits 11:0: data select;
    - bits 15:12: ALU opcode;
    - bits 23:16: per-direction output select.
- One sub-module, `context_mem`: simple dual-port, `Depth`×`ContextWidth`, sync write, registered read-before-write. The sequencer FSM and counters live in the top module.

## Test plan
- Load mem[0..2] = 24'h010001, 24'h020000, 24'h030001; `start` with `ctx_len`=3, `iter_cnt`=2 at T → `configuration` sequence 010001, 020000, 030001, 010001, 020000, 030001 in T+1..T+6. Then held through T+8, `done` at T+9, `busy` low at T+9.
- `start` with `ctx_len`=0 → `err` at T+1, `busy` stays 0, `configuration` unchanged. Repeat with `ctx_len`=17 and with `iter_cnt`=0 → same response.
- During a run (`ctx_len`=4, `iter_cnt`=3), write 24'hFFFFFF to addr 1 → write dropped; the next run still issues the original mem[1]. A second `start` mid-run is ignored: no `err`, same `done` cycle.
- Assert `rst` at T+3 of a 10-word run → all outputs at reset values from T+4, no `done` ever. A fresh `start` at T+6 runs normally from mem[0] with memory contents preserved.
- Write addr 0 = 24'h0000AA in the same cycle as `start` (old mem[0] = 24'h000055) → first issued word 24'h000055, and the next run issues 24'h0000AA.
- `ctx_len`=16, `iter_cnt`=1 → 16 consecutive words with `ctx_idx` 0..15 and no wrap glitch, then `done` at T+19.

Source files
------------

// File: rtl/pe_context_sequencer_pkg.sv
// Shared types and constants for the PE context sequencer and PE tooling.
// Holds the FSM state encoding, default sizes and context-word field positions.
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int unsigned CONTEXT_WIDTH = 24;
  localparam int unsigned DEPTH         = 16;
  localparam int unsigned ADDR_WIDTH    = $clog2(DEPTH);
  localparam int unsigned ITER_WIDTH    = 16;
  localparam int unsigned DRAIN_CYCLES  = 2;

  // Context-word layout as seen by the PE configuration port.
  localparam int unsigned BANK_SEL_BIT = 0;
  localparam int unsigned DATA_SEL_LSB = 0;
  localparam int unsigned DATA_SEL_MSB = 11;
  localparam int unsigned ALU_OP_LSB   = 12;
  localparam int unsigned ALU_OP_MSB   = 15;
  localparam int unsigned OUT_SEL_LSB  = 16;
  localparam int unsigned OUT_SEL_MSB  = 23;

endpackage

// File: rtl/pe_context_sequencer_if.sv
// Host-side bundle of the context sequencer: memory load, run control, status
// and the configuration word driven towards the PE.
interface pe_context_sequencer_if #(
  parameter int unsigned ContextWidth = 24,
  parameter int unsigned AddrWidth    = 4,
  parameter int unsigned IterWidth    = 16
);

  logic                    cfg_wr_en;
  logic [AddrWidth-1:0]    cfg_wr_addr;
  logic [ContextWidth-1:0] cfg_wr_data;
  logic                    start;
  logic [AddrWidth:0]      ctx_len;
  logic [IterWidth-1:0]    iter_cnt;
  logic [ContextWidth-1:0] configuration;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [AddrWidth-1:0]    ctx_idx;
  logic [IterWidth-1:0]    iter_idx;

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, start, ctx_len, iter_cnt,
    input  configuration, busy, done, err, ctx_idx, iter_idx
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, start, ctx_len, iter_cnt,
    output configuration, busy, done, err, ctx_idx, iter_idx
  );

endinterface

// File: rtl/pe_context_sequencer_context_mem.sv
// Simple dual-port context store: synchronous write, registered read that
// returns the pre-write contents when both ports hit the same address.
module context_mem #(
  parameter int unsigned Width     = 24,
  parameter int unsigned Depth     = 16,
  parameter int unsigned AddrWidth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [Width-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [Width-1:0]     rd_data
);

  logic [Width-1:0] mem [Depth];

  // NOTE: the array has no reset so it maps onto RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Holding rd_data when rd_en is low keeps the last issued word on the PE port.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pe_context_sequencer.sv
// Replays ctx_len context words for iter_cnt iterations onto the PE
// configuration port, then drains DrainCycles cycles and pulses done.
module pe_context_sequencer
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned ContextWidth = CONTEXT_WIDTH,
  parameter int unsigned Depth        = DEPTH,
  parameter int unsigned AddrWidth    = ADDR_WIDTH,
  parameter int unsigned IterWidth    = ITER_WIDTH,
  parameter int unsigned DrainCycles  = DRAIN_CYCLES
) (
  input logic                  clk,
  input logic                  rst,
  pe_context_sequencer_if.slave bus
);

  localparam int unsigned DrainW = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
  localparam logic [AddrWidth:0]  DepthLen  = (AddrWidth + 1)'(Depth);
  localparam logic [DrainW-1:0]   DrainLast = DrainW'(DrainCycles - 1);

  seq_state_e           state;
  logic [AddrWidth:0]   len_q;
  logic [IterWidth-1:0] iter_q;
  logic [AddrWidth-1:0] ctx_idx_q;
  logic [IterWidth-1:0] iter_idx_q;
  logic [DrainW-1:0]    drain_cnt;
  logic                 busy_q, done_q, err_q;

  logic                    start_bad, ctx_wrap, last_word, rd_en, mem_wr_en;
  logic [AddrWidth-1:0]    rd_addr;
  logic [ContextWidth-1:0] rd_data;

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    start_bad = (bus.ctx_len == '0) || (bus.ctx_len > DepthLen) || (bus.iter_cnt == '0);
    ctx_wrap  = ({1'b0, ctx_idx_q} == len_q - 1'b1);
    last_word = ctx_wrap && (iter_idx_q == iter_q - 1'b1);
    mem_wr_en = bus.cfg_wr_en && !busy_q;
    rd_en     = 1'b0;
    rd_addr   = '0;
    unique case (state)
      IDLE: rd_en = bus.start && !start_bad;
      RUN: begin
        // Fetch one word ahead so the registered read lines up with ctx_idx.
        rd_en   = !last_word;
        rd_addr = ctx_wrap ? '0 : ctx_idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  context_mem #(
    .Width    (ContextWidth),
    .Depth    (Depth),
    .AddrWidth(AddrWidth)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (mem_wr_en),
    .wr_addr(bus.cfg_wr_addr),
    .wr_data(bus.cfg_wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // NOTE: non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      iter_q     <= '0;
      ctx_idx_q  <= '0;
      iter_idx_q <= '0;
      drain_cnt  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (start_bad) begin
              err_q <= 1'b1;
            end else begin
              state      <= RUN;
              busy_q     <= 1'b1;
              len_q      <= bus.ctx_len;
              iter_q     <= bus.iter_cnt;
              ctx_idx_q  <= '0;
              iter_idx_q <= '0;
            end
          end
        end
        RUN: begin
          if (last_word) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else if (ctx_wrap) begin
            ctx_idx_q  <= '0;
            iter_idx_q <= iter_idx_q + 1'b1;
          end else begin
            ctx_idx_q <= ctx_idx_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DrainLast) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.configuration = rd_data;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.ctx_idx       = ctx_idx_q;
  assign bus.iter_idx      = iter_idx_q;

endmodule

// File: tb/tb_pe_context_sequencer.sv
// Directed bench for pe_context_sequencer: a memory model fills a scoreboard
// of expected words at each start; the DUT output stream is popped against it.
module tb_pe_context_sequencer;
  import pe_ctrl_pkg::*;

  localparam int CW = CONTEXT_WIDTH;
  localparam int D  = DEPTH;
  localparam int AW = ADDR_WIDTH;
  localparam int IW = ITER_WIDTH;
  localparam int DC = DRAIN_CYCLES;

  typedef struct packed {
    logic [CW-1:0] cfg;
    logic [AW-1:0] ci;
    logic [IW-1:0] ii;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_context_sequencer_if #(.ContextWidth(CW), .AddrWidth(AW), .IterWidth(IW)) bus ();

  pe_context_sequencer #(
    .ContextWidth(CW), .Depth(D), .AddrWidth(AW), .IterWidth(IW), .DrainCycles(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int            checks = 0;
  int            errors = 0;
  exp_t          sb[$];
  logic [CW-1:0] model[D];
  logic [CW-1:0] last_cfg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [CW-1:0] data);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_addr = AW'(addr);
    bus.cfg_wr_data = data;
    tick();
    bus.cfg_wr_en = 1'b0;
    model[addr]   = data;
  endtask

  // Drives start for one cycle (cycle T); returns in T+1.
  task automatic launch(input int len, input int iter);
    exp_t e;
    bus.start    = 1'b1;
    bus.ctx_len  = (AW + 1)'(len);
    bus.iter_cnt = IW'(iter);
    if (len >= 1 && len <= D && iter >= 1) begin
      for (int i = 0; i < iter; i++) begin
        for (int c = 0; c < len; c++) begin
          e.cfg = model[c];
          e.ci  = AW'(c);
          e.ii  = IW'(i);
          sb.push_back(e);
        end
      end
    end
    tick();
    bus.start = 1'b0;
  endtask

  // Checks words, drain, done pulse. inj_at>0 drops a write and a second start mid-run.
  task automatic expect_run(input int inj_at);
    exp_t e;
    int   k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      k++;
      check("run_cfg", 32'(bus.configuration), 32'(e.cfg));
      check("run_ctx_idx", 32'(bus.ctx_idx), 32'(e.ci));
      check("run_iter_idx", 32'(bus.iter_idx), 32'(e.ii));
      check("run_busy", 32'(bus.busy), 32'd1);
      check("run_err", 32'(bus.err), 32'd0);
      check("run_done", 32'(bus.done), 32'd0);
      last_cfg = e.cfg;
      if (k == inj_at) begin
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_addr = AW'(1);
        bus.cfg_wr_data = 24'hFFFFFF;
        bus.start       = 1'b1;
        bus.ctx_len     = (AW + 1)'(1);
        bus.iter_cnt    = IW'(1);
      end
      tick();
      bus.cfg_wr_en = 1'b0;
      bus.start     = 1'b0;
    end
    for (int d = 0; d < DC; d++) begin
      check("drain_cfg", 32'(bus.configuration), 32'(last_cfg));
      check("drain_busy", 32'(bus.busy), 32'd1);
      check("drain_done", 32'(bus.done), 32'd0);
      check("drain_err", 32'(bus.err), 32'd0);
      tick();
    end
    check("done_pulse", 32'(bus.done), 32'd1);
    check("done_busy", 32'(bus.busy), 32'd0);
    check("done_cfg", 32'(bus.configuration), 32'(last_cfg));
    tick();
    check("done_clear", 32'(bus.done), 32'd0);
    check("idle_cfg", 32'(bus.configuration), 32'(last_cfg));
  endtask

  task automatic reject(input int len, input int iter);
    launch(len, iter);
    check("rej_err", 32'(bus.err), 32'd1);
    check("rej_busy", 32'(bus.busy), 32'd0);
    check("rej_cfg", 32'(bus.configuration), 32'(last_cfg));
    tick();
    check("rej_err_clear", 32'(bus.err), 32'd0);
    check("rej_busy_after", 32'(bus.busy), 32'd0);
    check("rej_cfg_after", 32'(bus.configuration), 32'(last_cfg));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst             = 1'b1;
    bus.cfg_wr_en   = 1'b0;
    bus.cfg_wr_addr = '0;
    bus.cfg_wr_data = '0;
    bus.start       = 1'b0;
    bus.ctx_len     = '0;
    bus.iter_cnt    = '0;
    last_cfg        = '0;
    repeat (3) tick();
    check("rst_cfg", 32'(bus.configuration), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_ctx_idx", 32'(bus.ctx_idx), 32'd0);
    check("rst_iter_idx", 32'(bus.iter_idx), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < D; i++) write_word(i, CW'(32'h0A0000 + i * 32'h1011));
    write_word(0, 24'h010001);
    write_word(1, 24'h020000);
    write_word(2, 24'h030001);

    // Basic 3x2 run.
    launch(3, 2);
    expect_run(0);

    // Illegal starts.
    reject(0, 1);
    reject(17, 1);
    reject(3, 0);

    // Write and second start during a run are ignored.
    launch(4, 3);
    expect_run(5);
    launch(4, 1);
    expect_run(0);

    // Reset at T+3 of a 10-word run.
    launch(5, 2);
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      check("pre_rst_cfg", 32'(bus.configuration), 32'(e.cfg));
      if (k < 2) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    last_cfg = '0;
    check("abort_cfg", 32'(bus.configuration), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_err", 32'(bus.err), 32'd0);
    check("abort_ctx_idx", 32'(bus.ctx_idx), 32'd0);
    check("abort_iter_idx", 32'(bus.iter_idx), 32'd0);
    tick();
    check("abort_no_done", 32'(bus.done), 32'd0);
    check("abort_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    launch(3, 1);
    expect_run(0);

    // Write to address 0 in the start cycle: old word issued first.
    write_word(0, 24'h000055);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_addr = '0;
    bus.cfg_wr_data = 24'h0000AA;
    launch(1, 1);
    bus.cfg_wr_en = 1'b0;
    model[0]      = 24'h0000AA;
    expect_run(0);
    launch(1, 1);
    expect_run(0);

    // Full-depth single iteration.
    launch(16, 1);
    expect_run(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
